big_fifo_ctrl: RTL and testbench

Controller that turns the single-port 16-bit synchronous-read sample RAM into a streaming FIFO for audio sample buffering. Sits directly upstream of the big sample memory: it accepts 16-bit words on a valid/ready input stream, time-multiplexes the memory's single port between writes and reads, and delivers words in order on a valid/ready output stream toward the DAC path. The memory itself is instantiated outside this block and connected through the `mem_*` ports.

---
 rtl/big_fifo_pkg.sv | 13 +
 rtl/big_fifo_out_buf.sv | 61 ++++++
 rtl/big_fifo_ctrl.sv | 134 +++++++++++++
 tb/tb_big_fifo_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/big_fifo_pkg.sv
// Shared types and constants for the big sample-RAM FIFO controller.
// Optional watermark output is enabled with BIG_FIFO_WATERMARK_EN.
package big_fifo_pkg;

   localparam int DATA_WIDTH     = 16;
   localparam int DEF_ADDR_WIDTH = 23;

   typedef enum logic {
      ARB_WRITE_PRI = 1'b0,
      ARB_READ_PRI  = 1'b1
   } arb_state_e;

endpackage

// File: rtl/big_fifo_out_buf.sv
// Two-entry in-order output buffer fed from the memory read port.
// Entry 0 is always the head; head_data reads as zero while empty.
module big_fifo_out_buf
   import big_fifo_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic                  head_valid,
   output logic [1:0]            count
);

   logic [1:0]            count_q, count_d;
   logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
   logic [DATA_WIDTH-1:0] ent1_q, ent1_d;

   always_comb begin
      count_d = count_q;
      ent0_d  = ent0_q;
      ent1_d  = ent1_q;
      case ({push, pop})
         2'b10: begin
            if (count_q == 2'd0) ent0_d = push_data;
            else                 ent1_d = push_data;
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            ent0_d  = ent1_q;
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            // Occupancy unchanged: the new word lands behind whatever survives the pop.
            if (count_q == 2'd1) begin
               ent0_d = push_data;
            end else begin
               ent0_d = ent1_q;
               ent1_d = push_data;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) count_q <= 2'd0;
      else          count_q <= count_d;
   end

   always_ff @(posedge clk) begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
   end

   assign head_valid = (count_q != 2'd0);
   assign head_data  = head_valid ? ent0_q : '0;
   assign count      = count_q;

endmodule

// File: rtl/big_fifo_ctrl.sv
// Streams 16-bit samples through a single-port sync-read RAM as a FIFO.
// Define BIG_FIFO_WATERMARK_EN to add the registered half_full output.
module big_fifo_ctrl
   import big_fifo_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_din,
   input  logic [DATA_WIDTH-1:0] mem_dout
`ifdef BIG_FIFO_WATERMARK_EN
   ,
   output logic                  half_full
`endif
);

   localparam logic [ADDR_WIDTH:0] DEPTH_L = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   logic                  hold_valid_q, hold_valid_d;
   logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
   logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  inflight_q, inflight_d;
   arb_state_e            arb_q, arb_d;

   logic                  empty, full, in_fire;
   logic                  want_wr, want_rd, grant_wr, grant_rd;
   logic [1:0]            out_count;

   assign level     = wr_ptr_q - rd_ptr_q;
   assign empty     = (level == '0);
   assign full      = (level == DEPTH_L);
   assign in_ready  = !hold_valid_q;
   assign in_fire   = in_valid & !hold_valid_q;

   // A read is only issued if its returning word is guaranteed a buffer slot.
   assign want_wr   = hold_valid_q & !full;
   assign want_rd   = !empty & ((out_count + {1'b0, inflight_q}) < 2'd2);
   assign grant_wr  = want_wr & (!want_rd | (arb_q == ARB_WRITE_PRI));
   assign grant_rd  = want_rd & !grant_wr;

   always_comb begin
      hold_valid_d = hold_valid_q;
      hold_data_d  = hold_data_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      addr_d       = addr_q;
      arb_d        = arb_q;
      inflight_d   = grant_rd;

      if (in_fire) begin
         hold_valid_d = 1'b1;
         hold_data_d  = in_data;
      end
      if (grant_wr) begin
         hold_valid_d = 1'b0;
         wr_ptr_d     = wr_ptr_q + PTR_ONE;
         addr_d       = wr_ptr_q[ADDR_WIDTH-1:0];
      end
      if (grant_rd) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
         addr_d   = rd_ptr_q[ADDR_WIDTH-1:0];
      end
      if (want_wr && want_rd) begin
         arb_d = (arb_q == ARB_WRITE_PRI) ? ARB_READ_PRI : ARB_WRITE_PRI;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_valid_q <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         addr_q       <= '0;
         inflight_q   <= 1'b0;
         arb_q        <= ARB_READ_PRI;
      end else begin
         hold_valid_q <= hold_valid_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         addr_q       <= addr_d;
         inflight_q   <= inflight_d;
         arb_q        <= arb_d;
      end
   end

   always_ff @(posedge clk) begin
      hold_data_q <= hold_data_d;
   end

   // Idle cycles keep the previous address on the bus.
   assign mem_we   = grant_wr;
   assign mem_addr = addr_d;
   assign mem_din  = grant_wr ? hold_data_q : '0;

   big_fifo_out_buf u_out_buf (
      .clk        (clk),
      .reset_n    (reset_n),
      .push       (inflight_q),
      .push_data  (mem_dout),
      .pop        (out_valid & out_ready),
      .head_data  (out_data),
      .head_valid (out_valid),
      .count      (out_count)
   );

`ifdef BIG_FIFO_WATERMARK_EN
   localparam logic [ADDR_WIDTH:0] HALF_L = {2'b01, {(ADDR_WIDTH-1){1'b0}}};

   logic half_full_q, half_full_d;

   assign half_full_d = (level >= HALF_L);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) half_full_q <= 1'b0;
      else          half_full_q <= half_full_d;
   end

   assign half_full = half_full_q;
`endif

endmodule

// File: tb/tb_big_fifo_ctrl.sv
// Bench for big_fifo_ctrl with a 16-word RAM model and an in-order scoreboard.
// Exercises half_full as well when BIG_FIFO_WATERMARK_EN is defined.
module tb_big_fifo_ctrl;
   import big_fifo_pkg::*;

   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [15:0]   in_data;
   logic          in_valid;
   logic          in_ready;
   logic [15:0]   out_data;
   logic          out_valid;
   logic          out_ready;
   logic [AW:0]   level;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [15:0]   mem_din;
   logic [15:0]   mem_dout;
`ifdef BIG_FIFO_WATERMARK_EN
   logic          half_full;
`endif

   always #5 clk = ~clk;

   big_fifo_ctrl #(.ADDR_WIDTH(AW)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .level     (level),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout)
`ifdef BIG_FIFO_WATERMARK_EN
      ,
      .half_full (half_full)
`endif
   );

   // Single-port synchronous-read sample RAM.
   logic [15:0] ram [16];
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      else        mem_dout <= ram[mem_addr];
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // Reference model: every accepted word must be written to memory in order, at
   // consecutive addresses modulo DEPTH, and later delivered in the same order.
   logic [15:0] exp_q[$];
   logic [15:0] wr_q[$];
   int          n_out = 0;
   int          n_we  = 0;
   int          n_wr_rst = 0;
   logic        prev_we = 1'b0;
   logic [AW:0] prev_level = '0;

   always @(negedge clk) begin
      if (!reset_n) begin
         exp_q.delete();
         wr_q.delete();
         n_wr_rst   = 0;
         prev_we    = 1'b0;
         prev_level = '0;
      end else begin
         check("we_back_to_back", {31'd0, prev_we & mem_we}, 32'd0);
         if (mem_we) begin
            n_we++;
            check("wr_addr", {28'd0, mem_addr}, n_wr_rst % 16);
            n_wr_rst++;
            if (wr_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL wr_unexpected: actual write %0h required none", mem_din);
            end else begin
               check("wr_data", {16'd0, mem_din}, {16'd0, wr_q.pop_front()});
            end
         end
         prev_we = mem_we;
`ifdef BIG_FIFO_WATERMARK_EN
         check("half_full", {31'd0, half_full}, {31'd0, prev_level >= 5'd8});
         prev_level = level;
`endif
         if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL out_unexpected: actual %0h required none", out_data);
            end else begin
               check("out_order", {16'd0, out_data}, {16'd0, exp_q.pop_front()});
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(in_data);
            wr_q.push_back(in_data);
         end
      end
   end

   task automatic push_word(input logic [15:0] w, input int budget);
      int n = 0;
      in_valid = 1'b1;
      in_data  = w;
      @(negedge clk);
      while (!in_ready && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("push_accepted", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      out_ready = 1'b1;
      while ((exp_q.size() != 0 || out_valid) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("drain_done", {31'd0, (exp_q.size() == 0) && !out_valid && (level == '0)}, 32'd1);
   endtask

   typedef struct {
      logic          vin;
      logic [15:0]   din;
      logic          ordy;
      logic          inr;
      logic          ov;
      logic [15:0]   od;
      logic          we;
      logic [AW-1:0] addr;
      logic [AW:0]   lvl;
      logic [15:0]   mdin;
   } vec_t;

   vec_t vec[13];

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, s_out, s_we, n;
      logic prod_done;

      // Cycle-by-cycle trace: one word, then two back-to-back words with a stalled consumer.
      vec[0]  = '{1'b1, 16'h1234, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd0, 5'd0, 16'h0000};
      vec[1]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 4'd0, 5'd0, 16'h1234};
      vec[2]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd0, 5'd1, 16'h0000};
      vec[3]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd0, 5'd0, 16'h0000};
      vec[4]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b0, 4'd0, 5'd0, 16'h0000};
      vec[5]  = '{1'b1, 16'hA5A5, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd0, 5'd0, 16'h0000};
      vec[6]  = '{1'b1, 16'h5A5A, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 4'd1, 5'd0, 16'hA5A5};
      vec[7]  = '{1'b1, 16'h5A5A, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd1, 5'd1, 16'h0000};
      vec[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 4'd2, 5'd0, 16'h5A5A};
      vec[9]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'hA5A5, 1'b0, 4'd2, 5'd1, 16'h0000};
      vec[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'hA5A5, 1'b0, 4'd2, 5'd0, 16'h0000};
      vec[11] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h5A5A, 1'b0, 4'd2, 5'd0, 16'h0000};
      vec[12] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd2, 5'd0, 16'h0000};

      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data",  {16'd0, out_data}, 32'd0);
      check("rst_level",     {27'd0, level}, 32'd0);
      check("rst_mem_we",    {31'd0, mem_we}, 32'd0);
      check("rst_mem_addr",  {28'd0, mem_addr}, 32'd0);
      check("rst_mem_din",   {16'd0, mem_din}, 32'd0);
      reset_n = 1'b1;
      #1;
      check("rst_in_ready",  {31'd0, in_ready}, 32'd1);

      for (int i = 0; i < 13; i++) begin
         @(posedge clk);
         #1;
         in_valid  = vec[i].vin;
         in_data   = vec[i].din;
         out_ready = vec[i].ordy;
         @(negedge clk);
         check($sformatf("v%0d_in_ready", i),  {31'd0, in_ready}, {31'd0, vec[i].inr});
         check($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vec[i].ov});
         check($sformatf("v%0d_out_data", i),  {16'd0, out_data}, {16'd0, vec[i].od});
         check($sformatf("v%0d_mem_we", i),    {31'd0, mem_we}, {31'd0, vec[i].we});
         check($sformatf("v%0d_mem_addr", i),  {28'd0, mem_addr}, {28'd0, vec[i].addr});
         check($sformatf("v%0d_level", i),     {27'd0, level}, {27'd0, vec[i].lvl});
         if (vec[i].we) check($sformatf("v%0d_mem_din", i), {16'd0, mem_din}, {16'd0, vec[i].mdin});
      end

      // Fill to capacity with the consumer stalled.
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      base = n_out;
      for (int w = 0; w < 19; w++) push_word(16'(w), 50);
      in_valid = 1'b1;
      in_data  = 16'd19;
      repeat (12) @(negedge clk);
      check("full_in_ready",  {31'd0, in_ready}, 32'd0);
      check("full_level",     {27'd0, level}, 32'd16);
      check("full_out_valid", {31'd0, out_valid}, 32'd1);
      check("full_out_data",  {16'd0, out_data}, 32'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      push_word(16'd19, 100);
      wait_drain(200);
      check("full_total_out", n_out - base, 32'd20);

      // Random producer gaps and random consumer stalls across several address wraps.
      base = n_out;
      prod_done = 1'b0;
      fork
         begin
            for (int w = 0; w < 40; w++) begin
               repeat ($urandom_range(0, 2)) begin
                  @(posedge clk);
                  #1;
               end
               push_word(16'($urandom), 100);
            end
            prod_done = 1'b1;
         end
         begin
            while (!prod_done) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      wait_drain(200);
      check("wrap_total_out", n_out - base, 32'd40);

      // Both streams continuously active.
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      fork
         for (int w = 0; w < 60; w++) push_word(16'(16'h0100 + w), 100);
         begin
            repeat (20) @(negedge clk);
            s_out = n_out;
            s_we  = n_we;
            repeat (40) @(negedge clk);
            check("stream_out_rate", {31'd0, (n_out - s_out) >= 19 && (n_out - s_out) <= 21}, 32'd1);
            check("stream_we_rate",  {31'd0, (n_we - s_we) >= 19 && (n_we - s_we) <= 21}, 32'd1);
         end
      join
      wait_drain(100);

      // Reset while words are stored and a read is returning.
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      for (int w = 0; w < 8; w++) push_word(16'(16'h0200 + w), 50);
      repeat (10) @(negedge clk);
      check("pre_rst_level", {27'd0, level}, 32'd6);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      check("pre_rst_level5", {27'd0, level}, 32'd5);
      reset_n = 1'b0;
      #1;
      check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_level",     {27'd0, level}, 32'd0);
      check("mid_rst_in_ready",  {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(negedge clk);
      check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("post_rst_level",     {27'd0, level}, 32'd0);
      check("post_rst_in_ready",  {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      push_word(16'hBEEF, 10);
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("post_rst_first_word", {16'd0, out_data}, 32'h0000BEEF);
      wait_drain(50);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
